// File: rtl/cla_sched_pkg.sv
// cla_sched_pkg: shared types and sizing for the shared-adder scheduler
// The tag id width is fixed here, so the top's NREQ must stay at NREQ_CFG.
package cla_sched_pkg;
  localparam int NREQ_CFG = 4;
  localparam int ID_W = $clog2(NREQ_CFG);
  typedef enum logic [1:0] {RUN, DRAIN, HALT} sched_state_t;
  typedef struct packed {
    logic v;
    logic [ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/cla_share_sched_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant searching upward from a rotating pointer
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            res,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt
);
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0] ptr_q, ptr_d;
  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v % NREQ);
  endfunction
  // Walk the offsets from the far end down so the nearest requester overrides.
  always_comb begin
    gnt = '0;
    ptr_d = ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (en && req[wrap(int'(ptr_q) + k)]) begin
        gnt = '0;
        gnt[wrap(int'(ptr_q) + k)] = 1'b1;
        ptr_d = wrap(int'(ptr_q) + k + 1);
      end
    end
  end
  always_ff @(posedge clk or negedge res) begin
    if (!res) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/cla_share_sched.sv
// cla_share_sched: round-robin scheduler sharing one pipelined CLA among NREQ requesters
module cla_share_sched
  import cla_sched_pkg::*;
#(
  parameter int NREQ    = NREQ_CFG,
  parameter int W       = 4,
  parameter int ADD_LAT = 4
) (
  input  logic              clk,
  input  logic              res,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  input  logic [NREQ-1:0]   req_cin,
  input  logic              hold,
  output logic              add_valid,
  output logic [W-1:0]      add_x,
  output logic [W-1:0]      add_y,
  output logic              add_cin,
  input  logic [W-1:0]      add_z,
  input  logic              add_cout,
  output logic              rsp_valid,
  output logic [ID_W-1:0]   rsp_id,
  output logic [W-1:0]      rsp_z,
  output logic              rsp_cout,
  output logic              halted
);
  sched_state_t state_q, state_d;
  logic issue_en, in_flight;
  logic [NREQ-1:0] gnt;
  logic add_valid_q, add_valid_d, add_cin_q, add_cin_d;
  logic [W-1:0] add_x_q, add_x_d, add_y_q, add_y_d;
  logic [ID_W-1:0] add_id_q, add_id_d;
  tag_t tag_q [ADD_LAT];
  tag_t tag_d [ADD_LAT];
  tag_t tail;
  logic rsp_valid_q, rsp_valid_d, rsp_cout_q, rsp_cout_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [W-1:0] rsp_z_q, rsp_z_d;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk(clk),
    .res(res),
    .en(issue_en),
    .req(req_valid),
    .gnt(gnt)
  );
  always_comb begin
    in_flight = add_valid_q;
    for (int i = 0; i < ADD_LAT; i++) in_flight = in_flight | tag_q[i].v;
  end
  always_comb begin
    state_d = !hold ? RUN : (state_q == HALT || !in_flight) ? HALT : DRAIN;
  end
  // Gating with res keeps req_ready low while reset holds the issue stage.
  always_comb begin
    issue_en = (state_q == RUN) && !hold && res;
    req_ready = gnt;
    halted = (state_q == HALT);
  end
  always_comb begin
    add_valid_d = |gnt;
    add_x_d = add_x_q;
    add_y_d = add_y_q;
    add_cin_d = add_cin_q;
    add_id_d = add_id_q;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        add_x_d = req_x[i*W +: W];
        add_y_d = req_y[i*W +: W];
        add_cin_d = req_cin[i];
        add_id_d = ID_W'(i);
      end
    end
  end
  always_comb begin
    tag_d[0] = '{v: add_valid_q, id: add_id_q};
    for (int i = 1; i < ADD_LAT; i++) tag_d[i] = tag_q[i-1];
  end
  // The pipe tail lines up with add_z/add_cout for the same operation.
  assign tail = tag_q[ADD_LAT-1];
  always_comb begin
    rsp_valid_d = tail.v;
    rsp_id_d = tail.v ? tail.id : rsp_id_q;
    rsp_z_d = tail.v ? add_z : rsp_z_q;
    rsp_cout_d = tail.v ? add_cout : rsp_cout_q;
  end
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= RUN;
      add_valid_q <= 1'b0;
      add_x_q <= '0;
      add_y_q <= '0;
      add_cin_q <= 1'b0;
      add_id_q <= '0;
      for (int i = 0; i < ADD_LAT; i++) tag_q[i] <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= '0;
      rsp_z_q <= '0;
      rsp_cout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      add_valid_q <= add_valid_d;
      add_x_q <= add_x_d;
      add_y_q <= add_y_d;
      add_cin_q <= add_cin_d;
      add_id_q <= add_id_d;
      for (int i = 0; i < ADD_LAT; i++) tag_q[i] <= tag_d[i];
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      rsp_z_q <= rsp_z_d;
      rsp_cout_q <= rsp_cout_d;
    end
  end
  assign add_valid = add_valid_q;
  assign add_x = add_x_q;
  assign add_y = add_y_q;
  assign add_cin = add_cin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = rsp_id_q;
  assign rsp_z = rsp_z_q;
  assign rsp_cout = rsp_cout_q;
endmodule

// File: tb/tb_cla_share_sched.sv
// tb_cla_share_sched: scoreboard bench for cla_share_sched driving a behavioural pipelined adder
module tb_cla_share_sched;
  localparam int NREQ = 4, W = 4, ADD_LAT = 4;
  logic clk, res, hold;
  logic [NREQ-1:0] req_valid, req_ready, req_cin;
  logic [NREQ*W-1:0] req_x, req_y;
  logic add_valid, add_cin, add_cout, rsp_valid, rsp_cout, halted;
  logic [W-1:0] add_x, add_y, add_z, rsp_z;
  logic [1:0] rsp_id;

  typedef struct { logic [W-1:0] x, y; logic cin; } op_t;
  typedef struct { int id; logic [W-1:0] z; logic c; } exp_t;
  op_t rq [NREQ][$];
  exp_t exp_q [$];
  int hs_q [$];
  int tests = 0, fails = 0, rsp_seen = 0, cyc = 0, n, base, h_m;
  exp_t e_m;

  cla_share_sched #(.NREQ(NREQ), .W(W), .ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .res(res), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_cin(req_cin), .hold(hold),
    .add_valid(add_valid), .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
    .add_z(add_z), .add_cout(add_cout), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_z(rsp_z), .rsp_cout(rsp_cout), .halted(halted)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External adder: ADD_LAT register stages, computed every cycle regardless of add_valid.
  logic [W:0] apipe [ADD_LAT];
  always @(posedge clk) begin
    apipe[0] <= {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_cin};
    for (int i = 1; i < ADD_LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign {add_cout, add_z} = apipe[ADD_LAT-1];

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic op(int r, logic [W-1:0] x, logic [W-1:0] y, logic cin,
                    logic [W-1:0] z, logic c, bit sb = 1);
    rq[r].push_back('{x, y, cin});
    if (sb) exp_q.push_back('{r, z, c});
  endtask

  function automatic bit pending();
    pending = 0;
    for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) pending = 1;
  endfunction

  task automatic wait_idle(string name);
    int k = 0;
    while ((exp_q.size() != 0 || pending()) && k < 100) begin
      @(negedge clk); #2; k++;
    end
    check({name, "_idle"}, int'(k < 100), 1);
  endtask

  task automatic check_reset(string name);
    check({name, "_req_ready"}, req_ready, 0);
    check({name, "_add_valid"}, add_valid, 0);
    check({name, "_add_x"}, add_x, 0);
    check({name, "_add_y"}, add_y, 0);
    check({name, "_add_cin"}, add_cin, 0);
    check({name, "_rsp_valid"}, rsp_valid, 0);
    check({name, "_rsp_id"}, rsp_id, 0);
    check({name, "_rsp_z"}, rsp_z, 0);
    check({name, "_rsp_cout"}, rsp_cout, 0);
    check({name, "_halted"}, halted, 0);
  endtask

  // Requester driver: presents each queue head, retires it on valid & ready.
  initial begin
    logic [NREQ-1:0] hs;
    req_valid = '0; req_x = '0; req_y = '0; req_cin = '0;
    forever begin
      @(negedge clk);
      check("ready_onehot", int'($onehot0(req_ready)), 1);
      hs = req_valid & req_ready;
      if (res)
        for (int i = 0; i < NREQ; i++)
          if (hs[i]) begin
            void'(rq[i].pop_front());
            hs_q.push_back(cyc);
          end
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = rq[i].size() != 0;
        if (rq[i].size() != 0) begin
          req_x[i*W +: W] = rq[i][0].x;
          req_y[i*W +: W] = rq[i][0].y;
          req_cin[i] = rq[i][0].cin;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever a response appears.
  initial forever begin
    @(negedge clk);
    if (res && rsp_valid) begin
      rsp_seen++;
      if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
      else begin
        e_m = exp_q.pop_front();
        check("rsp_id", rsp_id, e_m.id);
        check("rsp_z", rsp_z, e_m.z);
        check("rsp_cout", rsp_cout, e_m.c);
        h_m = -1;
        if (hs_q.size() != 0) h_m = hs_q.pop_front();
        check("rsp_latency", cyc - h_m, ADD_LAT + 2);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    res = 0; hold = 0;
    #12 check_reset("rst0");
    @(posedge clk); #1 res = 1;
    @(negedge clk); #2;
    // All four valid together: grants 0,1,2,3,0,1,2,3
    op(0, 4'h1, 4'h2, 0, 4'h3, 0); op(1, 4'h3, 4'h4, 1, 4'h8, 0);
    op(2, 4'h5, 4'h5, 0, 4'hA, 0); op(3, 4'h6, 4'h2, 1, 4'h9, 0);
    op(0, 4'h7, 4'h9, 1, 4'h1, 1); op(1, 4'hF, 4'hF, 0, 4'hE, 1);
    op(2, 4'h8, 4'h8, 1, 4'h1, 1); op(3, 4'hC, 4'h5, 0, 4'h1, 1);
    wait_idle("fair");
    op(0, 4'h9, 4'h8, 0, 4'h1, 1);
    wait_idle("single");
    op(1, 4'hF, 4'h0, 1, 4'h0, 1); op(1, 4'h0, 4'h0, 0, 4'h0, 0);
    wait_idle("cin");
    // Pointer reaches 3, then req2 alone is found by wrapping
    op(2, 4'h1, 4'h1, 0, 4'h2, 0); op(2, 4'h9, 4'h9, 0, 4'h2, 1);
    wait_idle("wrap");
    op(3, 4'hF, 4'h1, 0, 4'h0, 1); op(0, 4'h2, 4'h2, 0, 4'h4, 0);
    op(1, 4'hA, 4'h6, 0, 4'h0, 1); op(2, 4'h3, 4'h3, 1, 4'h7, 0);
    @(negedge clk); check("wrap_ptr", req_ready, 4'b1000);
    wait_idle("ptr3");
    // Hold with three operations in flight
    op(0, 4'h4, 4'h4, 0, 4'h8, 0); op(0, 4'hB, 4'hB, 0, 4'h6, 1); op(0, 4'hD, 4'h2, 1, 4'h0, 1);
    base = rsp_seen;
    n = 0;
    while (rq[0].size() != 0 && n < 50) begin @(negedge clk); #2; n++; end
    @(posedge clk); #1 hold = 1;
    op(1, 4'h7, 4'h1, 0, 4'h8, 0);
    n = 0;
    do begin
      @(negedge clk); check("hold_ready", req_ready, 0); n++;
    end while (!halted && n < 12);
    check("halted", halted, 1);
    check("drain_rsps", rsp_seen - base, 3);
    @(posedge clk); #1 hold = 0;
    @(negedge clk); check("resume_wait", req_ready, 0); check("halted_still", halted, 1);
    @(negedge clk); check("resume_grant", req_ready, 4'b0010); check("halted_clear", halted, 0);
    wait_idle("resume");
    // Reset with two operations in flight; their results must never surface
    op(2, 4'h5, 4'h6, 0, 4'h0, 0, 0); op(3, 4'hE, 4'h3, 0, 4'h0, 0, 0);
    n = 0;
    while ((rq[2].size() != 0 || rq[3].size() != 0) && n < 50) begin @(negedge clk); #2; n++; end
    @(posedge clk); #1;
    @(posedge clk); #1 res = 0;
    hs_q.delete();
    #1 check_reset("rst1");
    base = rsp_seen;
    op(0, 4'h1, 4'h1, 1, 4'h3, 0); op(1, 4'h8, 4'h7, 0, 4'hF, 0);
    op(2, 4'h8, 4'h7, 1, 4'h0, 1); op(3, 4'h0, 4'h0, 0, 4'h0, 0);
    @(negedge clk); @(negedge clk);
    check("rst_hold_ready", req_ready, 0);
    check("rst_hold_add_valid", add_valid, 0);
    @(posedge clk); #1 res = 1;
    @(negedge clk); check("rst_first_grant", req_ready, 4'b0001);
    repeat (ADD_LAT) @(negedge clk);
    check("rst_no_stale", rsp_seen - base, 0);
    wait_idle("post_rst");
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
